// File: rtl/albacore_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : albacore_io_ctrl
//  Brief    : Memory-mapped board I/O controller for the albacore bus.
//             Switch/button synchronisers, sticky button-edge flags, LED and
//             hex-display registers, prescaled timer with compare-match flag.
//  Revision : 1.0 - initial release
// ============================================================================
module albacore_io_ctrl #(
   parameter int                DATA_W         = 16,
   parameter int                ADDR_W         = 16,
   parameter logic [ADDR_W-1:0] IO_BASE        = 16'hFF00,
   parameter int                N_SW           = 16,
   parameter int                N_BTN          = 4,
   parameter int                BTN_ACTIVE_LOW = 1,
   parameter int                N_LEDR         = 16,
   parameter int                N_LEDG         = 8,
   parameter int                PRESCALE       = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic              we,
   output logic              io_hit,
   output logic [DATA_W-1:0] rd_data,
   input  logic [N_SW-1:0]   switch,
   input  logic [N_BTN-1:0]  button,
   output logic [N_LEDR-1:0] led_red,
   output logic [N_LEDG-1:0] led_green,
   output logic [15:0]       hex7_hex4,
   output logic [15:0]       hex3_hex0,
   output logic              irq
);

   // Prescaler needs at least one bit even when every cycle is a tick.
   localparam int              PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] C_PS_LAST  = PS_W'(PRESCALE - 1);
   // Raw level of a released button; synchronisers park here in reset.
   localparam logic [N_BTN-1:0] C_BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

   logic [N_SW-1:0]   r_sw_meta, r_sw_sync;
   logic [N_BTN-1:0]  r_btn_meta, r_btn_sync, r_btn_prev, r_btn_edge;
   logic [N_LEDR-1:0] r_ledr;
   logic [N_LEDG-1:0] r_ledg;
   logic [15:0]       r_hex_hi, r_hex_lo;
   logic [DATA_W-1:0] r_timer, r_timer_cmp;
   logic [PS_W-1:0]   r_presc;
   logic              r_match;

   logic [3:0]        w_off;
   logic              w_wr;
   logic [N_BTN-1:0]  w_btn_press, w_btn_rise, w_edge_clr;
   logic              w_tick, w_wr_timer, w_match_set, w_match_clr;
   logic [DATA_W-1:0] w_timer_inc, w_rd_sel;

   assign io_hit      = (addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
   assign w_off       = addr[3:0];
   assign w_wr        = we & io_hit;

   // Buttons normalised so that 1 always means pressed.
   assign w_btn_press = r_btn_sync ^ C_BTN_IDLE;
   assign w_btn_rise  = w_btn_press & ~r_btn_prev;
   assign w_edge_clr  = (w_wr && w_off == 4'd2) ? N_BTN'(din) : {N_BTN{1'b0}};

   assign w_tick      = (r_presc == C_PS_LAST);
   assign w_wr_timer  = w_wr && (w_off == 4'd7);
   assign w_timer_inc = r_timer + DATA_W'(1);
   // A timer write suppresses the tick, so it also cannot raise a match.
   assign w_match_set = w_tick && !w_wr_timer && (w_timer_inc == r_timer_cmp);
   assign w_match_clr = w_wr && (w_off == 4'd9) && din[0];

   assign led_red     = r_ledr;
   assign led_green   = r_ledg;
   assign hex7_hex4   = r_hex_hi;
   assign hex3_hex0   = r_hex_lo;
   assign irq         = r_match | (|r_btn_edge);

   // Two-flop synchronisers plus the previous pressed level for edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_meta  <= '0;
         r_sw_sync  <= '0;
         r_btn_meta <= C_BTN_IDLE;
         r_btn_sync <= C_BTN_IDLE;
         r_btn_prev <= '0;
      end else begin
         r_sw_meta  <= switch;
         r_sw_sync  <= r_sw_meta;
         r_btn_meta <= button;
         r_btn_sync <= r_btn_meta;
         r_btn_prev <= w_btn_press;
      end
   end

   // Sticky edge flags: a new edge beats a same-cycle write-1-to-clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_btn_edge <= '0;
      else        r_btn_edge <= (r_btn_edge & ~w_edge_clr) | w_btn_rise;
   end

   // Plain read/write registers, truncated to their widths.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ledr      <= '0;
         r_ledg      <= '0;
         r_hex_hi    <= '0;
         r_hex_lo    <= '0;
         r_timer_cmp <= '1;
      end else if (w_wr) begin
         case (w_off)
            4'd3:    r_ledr      <= N_LEDR'(din);
            4'd4:    r_ledg      <= N_LEDG'(din);
            4'd5:    r_hex_hi    <= 16'(din);
            4'd6:    r_hex_lo    <= 16'(din);
            4'd8:    r_timer_cmp <= din;
            default: ;
         endcase
      end
   end

   // Prescaler and timer; a write to TIMER restarts both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_timer <= '0;
      end else if (w_wr_timer) begin
         r_presc <= '0;
         r_timer <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
         r_timer <= w_timer_inc;
      end else begin
         r_presc <= r_presc + PS_W'(1);
      end
   end

   // Sticky compare-match flag: set beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_match <= 1'b0;
      else        r_match <= (r_match & ~w_match_clr) | w_match_set;
   end

   // Read mux over the pre-write register values.
   always_comb begin
      w_rd_sel = '0;
      case (w_off)
         4'd0:    w_rd_sel = DATA_W'(r_sw_sync);
         4'd1:    w_rd_sel = DATA_W'(w_btn_press);
         4'd2:    w_rd_sel = DATA_W'(r_btn_edge);
         4'd3:    w_rd_sel = DATA_W'(r_ledr);
         4'd4:    w_rd_sel = DATA_W'(r_ledg);
         4'd5:    w_rd_sel = DATA_W'(r_hex_hi);
         4'd6:    w_rd_sel = DATA_W'(r_hex_lo);
         4'd7:    w_rd_sel = r_timer;
         4'd8:    w_rd_sel = r_timer_cmp;
         4'd9:    w_rd_sel = DATA_W'({|r_btn_edge, r_match});
         default: w_rd_sel = '0;
      endcase
   end

   // Registered read data, zero outside the window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= '0;
      else        rd_data <= io_hit ? w_rd_sel : '0;
   end

endmodule
`default_nettype wire
